// File: rtl/dma_port_arbiter.sv
// dma_port_arbiter: round-robin arbiter giving two DMA requesters burst tenures on one L1 memory port.
// Optional per-requester beat statistics are built when DMA_PORT_ARBITER_STATS_EN is defined.
module dma_port_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_wdata,
  input  logic [3:0]            a_be,
  input  logic                  a_last,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [31:0]           a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [31:0]           b_wdata,
  input  logic [3:0]            b_be,
  input  logic                  b_last,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [31:0]           b_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  owner,
  output logic [15:0]           stat_a_beats,
  output logic [15:0]           stat_b_beats
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t r_state, w_next;
  logic r_ptr, r_rd_pend, r_rd_b;
  logic [8:0] r_cnt, w_cnt_inc;
  logic w_own_a, w_own_b, w_acc, w_we, w_last, w_end;
  // Outputs are masked while reset is high so an aborted tenure never touches memory.
  always_comb begin
    w_own_a   = !reset && r_state == OWN_A;
    w_own_b   = !reset && r_state == OWN_B;
    w_acc     = w_own_b ? b_req : (w_own_a && a_req);
    w_we      = w_own_b ? b_we : a_we;
    w_last    = w_own_b ? b_last : a_last;
    w_cnt_inc = r_cnt + 9'd1;
    w_end     = (w_own_a || w_own_b) && (!w_acc || w_last || w_cnt_inc == 9'(MAX_BURST));
  end
  always_comb begin
    w_next = (r_state == OWN_A || r_state == OWN_B) ? (w_end ? IDLE : r_state) :
             (a_req && b_req) ? (r_ptr ? OWN_B : OWN_A) :
             a_req ? OWN_A : b_req ? OWN_B : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_b    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ptr     <= w_end ? !w_own_b : r_ptr;
      r_cnt     <= w_end ? '0 : (w_acc ? w_cnt_inc : r_cnt);
      r_rd_pend <= w_acc && !w_we;
      r_rd_b    <= w_own_b;
    end
  end
  always_comb begin
    a_gnt     = w_own_a;
    b_gnt     = w_own_b;
    busy      = w_own_a || w_own_b;
    owner     = w_own_b;
    mem_en    = w_acc;
    mem_we    = w_acc && w_we;
    mem_addr  = w_own_b ? b_addr : a_addr;
    mem_wdata = w_own_b ? b_wdata : a_wdata;
    mem_be    = w_own_b ? b_be : a_be;
    a_rvalid  = !reset && r_rd_pend && !r_rd_b;
    b_rvalid  = !reset && r_rd_pend && r_rd_b;
    a_rdata   = a_rvalid ? mem_rdata : '0;
    b_rdata   = b_rvalid ? mem_rdata : '0;
  end
`ifdef DMA_PORT_ARBITER_STATS_EN
  logic [15:0] r_stat_a, r_stat_b;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_a <= '0;
      r_stat_b <= '0;
    end else begin
      r_stat_a <= (w_acc && w_own_a && r_stat_a != 16'hFFFF) ? r_stat_a + 16'd1 : r_stat_a;
      r_stat_b <= (w_acc && w_own_b && r_stat_b != 16'hFFFF) ? r_stat_b + 16'd1 : r_stat_b;
    end
  end
  assign stat_a_beats = r_stat_a;
  assign stat_b_beats = r_stat_b;
`else
  assign stat_a_beats = '0;
  assign stat_b_beats = '0;
`endif
endmodule

// File: tb/tb_dma_port_arbiter.sv
// tb_dma_port_arbiter: directed checks of arbitration, burst limits, read routing, reset and statistics.
module tb_dma_port_arbiter;
  logic clk = 0, reset = 1;
  logic a_req = 0, a_we = 0, a_last = 0, b_req = 0, b_we = 0, b_last = 0;
  logic [12:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic [3:0] a_be = 4'hF, b_be = 4'h3;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, mem_en, mem_we, busy, owner;
  logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata = '0;
  logic [12:0] mem_addr;
  logic [3:0] mem_be;
  logic [15:0] stat_a_beats, stat_b_beats;
  int n_cmp = 0, n_bad = 0;
`ifdef DMA_PORT_ARBITER_STATS_EN
  localparam logic [31:0] STAT4 = 32'd4;
`else
  localparam logic [31:0] STAT4 = 32'd0;
`endif

  dma_port_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be), .a_last(a_last),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be), .b_last(b_last),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner),
    .stat_a_beats(stat_a_beats), .stat_b_beats(stat_b_beats)
  );

  always #5 clk = ~clk;

  // Memory returns a tagged copy of the read address one cycle later.
  always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? (32'hC0DE0000 | 32'(mem_addr)) : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    a_req = 0; a_we = 0; a_last = 0; b_req = 0; b_we = 0; b_last = 0;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    int beats, n, cyc;
    step();
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_busy", {busy, owner, mem_en, mem_we}, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_stats", {stat_a_beats, stat_b_beats}, 0);
    // single requester 4-beat write burst
    do_reset();
    a_req = 1; a_we = 1; a_addr = 13'h010; a_last = 0;
    #1;
    chk("idle_gnt", a_gnt, 0);
    chk("idle_no_beat", mem_en, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      a_addr = 13'(16 + i); a_wdata = 32'h1000 + 32'(i); a_last = (i == 3);
      #1;
      chk("wr_gnt", a_gnt, 1);
      chk("wr_en", {mem_en, mem_we}, 2'b11);
      chk("wr_addr", mem_addr, 32'h10 + 32'(i));
      chk("wr_data", mem_wdata, 32'h1000 + 32'(i));
      chk("wr_be", mem_be, 4'hF);
    end
    step();
    a_req = 0; a_last = 0;
    #1;
    chk("wr_done_idle", {busy, a_gnt}, 0);
    chk("wr_stat_a", stat_a_beats, STAT4);
    // contention and round robin
    do_reset();
    a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    step();
    chk("rr_first_a", {a_gnt, b_gnt, owner}, 3'b100);
    a_last = 1;
    step();
    a_last = 0;
    chk("rr_gap", busy, 0);
    step();
    chk("rr_then_b", {a_gnt, b_gnt, owner}, 3'b011);
    b_last = 1;
    step();
    chk("rr_gap2", busy, 0);
    step();
    chk("rr_back_a", {a_gnt, b_gnt}, 2'b10);
    a_req = 0; b_req = 0; b_last = 0;
    step();
    // MAX_BURST limit
    do_reset();
    a_req = 1; a_we = 1; a_last = 0; b_req = 1; b_we = 1; b_last = 0;
    step();
    beats = 0;
    for (int k = 0; k < 16; k++) begin
      if (mem_en && a_gnt) beats++;
      step();
    end
    chk("burst_len", beats, 16);
    chk("burst_gap", busy, 0);
    step();
    chk("burst_b_served", b_gnt, 1);
    b_last = 1;
    step();
    b_req = 0; b_last = 0;
    step();
    chk("burst_a_resume", a_gnt, 1);
    a_req = 0;
    step();
    // read routing across a tenure switch
    do_reset();
    a_req = 1; a_we = 0; a_addr = 13'h1FFF; a_last = 1; b_req = 1; b_we = 1; b_last = 1;
    step();
    chk("rd_issue", {mem_en, mem_we}, 2'b10);
    chk("rd_addr", mem_addr, 32'h1FFF);
    step();
    a_req = 0; a_last = 0;
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 32'hC0DE1FFF);
    chk("rd_b_quiet", {b_rvalid, busy}, 0);
    chk("rd_b_rdata", b_rdata, 0);
    step();
    chk("rd_b_gnt", b_gnt, 1);
    chk("rd_a_once", a_rvalid, 0);
    chk("rd_a_rdata0", a_rdata, 0);
    b_req = 0; b_last = 0;
    step();
    chk("wr_no_rvalid", {a_rvalid, b_rvalid}, 0);
    // reset in the middle of a read burst
    do_reset();
    a_req = 1; a_we = 0; a_addr = 13'h020; a_last = 0;
    step();
    chk("mid_rd_beat", mem_en, 1);
    step();
    reset = 1;
    #1;
    chk("mid_rst_quiet", {a_rvalid, mem_en, busy, a_gnt}, 0);
    step();
    reset = 0; a_req = 0;
    #1;
    chk("post_rst_quiet", {a_rvalid, mem_en, busy, owner}, 0);
    chk("post_rst_stat", stat_a_beats, 0);
    step();
`ifdef DMA_PORT_ARBITER_STATS_EN
    // statistics saturation
    do_reset();
    a_req = 1; a_we = 1; a_last = 0;
    n = 0; cyc = 0;
    while (n < 65540 && cyc < 90000) begin
      if (mem_en) n++;
      step();
      cyc++;
    end
    chk("sat_beats_done", n, 65540);
    chk("sat_stat_a", stat_a_beats, 16'hFFFF);
    chk("sat_stat_b", stat_b_beats, 0);
    a_req = 0;
    step();
`else
    n = 0; cyc = 0;
    chk("stats_off_b", {stat_a_beats, stat_b_beats}, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
